hazard_sched_ctrl: RTL and testbench
====================================

// Module: hazard_sched_ctrl
// PURPOSE
//  Pipeline hazard scheduler for the 5-stage 16-bit core. Keeps a per-register scoreboard of
//  in-flight writes, stalls IF/ID and injects ID/EX bubbles on RAW hazards against the decode
//  stage's read ports, flushes younger stages on EX redirects, and sequences HLT drain.
//  Sits beside the ID stage; consumes its decoded addresses and read enables.
// PARAMETERS
//  NUM_REGS      16  architectural registers; R0 never busy
//  LOAD_LAT      1   bubbles required after LW before a consumer can issue (forwarding build)
//  NOFWD_LAT     2   bubbles required after any producer (no-forwarding build; RF write-before-read)
//  DRAIN_CYCLES  3   cycles after HLT leaves ID until EX/MEM/WB are empty
// PORTS
//  clk           in   1   core clock
//  rst           in   1   synchronous, active-high reset
//  id_valid      in   1   ID holds a real (non-bubble) instruction
//  id_op         in   4   instr[15:12] in ID
//  id_rs_addr    in   4   port-0 read address;  id_rs_re in 1 = port-0 read enable
//  id_rt_addr    in   4   port-1 read address;  id_rt_re in 1 = port-1 read enable
//  id_rd_addr    in   4   destination (R15 for JAL; 0 = no write)
//  ex_redirect   in   1   taken branch / JAL / JR resolved in EX
//  stall_if_id   out  1   hold PC and IF/ID register
//  bubble_id_ex  out  1   load NOP into ID/EX
//  flush_if_id   out  1   squash IF/ID contents
//  halted        out  1   core fully drained after HLT
// BEHAVIOUR
//  - Reset: all counters 0, FSM=RUN, all outputs 0.
//  - Scoreboard: cnt[r] 2 bits per register. Allocate when id_valid & ~stall & ~ex_redirect & rd!=0:
//    cnt[rd] = latency of op class (LW 1000 -> load; ALU, LHB/LLB, JAL -> alu). Non-allocated nonzero
//    counters decrement by 1 every cycle (bubbles still advance EX/MEM/WB). WAW: allocation overwrites.
//  - Hazard (combinational): (rs_re & rs!=0 & cnt[rs]!=0) | (rt_re & rt!=0 & cnt[rt]!=0), gated by id_valid.
//    Hazard -> stall_if_id=1, bubble_id_ex=1 same cycle; no allocation that cycle.
//  - ex_redirect: flush_if_id=1, bubble_id_ex=1, stall_if_id=0, no allocation; redirect beats hazard.
//    Counters of older instructions in EX/MEM/WB keep decrementing.
//  - FSM RUN: HLT (1111) issuing from ID without hazard/redirect -> DRAIN, drain_cnt=DRAIN_CYCLES.
//    DRAIN: stall_if_id=1, bubble_id_ex=1 every cycle; drain_cnt-- ; at 0 and all cnt==0 -> HALTED.
//    DRAIN + ex_redirect: return to RUN (HLT was wrong-path), flush as normal.
//    HALTED: halted=1, stall_if_id=1, sticky until rst.
//  - rst mid-stall/mid-drain: everything cleared next edge, no outputs held.
//  - Outputs are combinational from state + ID inputs; no added latency on stall.
// CONFIGURATION
//  HAZARD_FWD_EN defined: EX/MEM forwarding present; alu latency 0 (never stalls), load latency LOAD_LAT.
//  HAZARD_FWD_EN undefined: every producer latency NOFWD_LAT; RF writes first half, reads second.
// STRUCTURE
//  Package hazard_ctrl_pkg: opcode constants (OP_LW 1000, OP_SW 1001, OP_LHB 1010, OP_LLB 1011,
//  OP_B 1100, OP_JAL 1101, OP_JR 1110, OP_HLT 1111), FSM state enum, latency class typedef.
//  One sub-module: hazard_scoreboard (counter array, alloc/decrement, busy lookup for two ports).
// TESTING
//  1 FWD: LW R1; ADD R2,R1,R3 -> exactly 1 cycle stall_if_id=bubble_id_ex=1, then ADD issues.
//  2 FWD: ADD R1; SUB R4,R1,R1 -> no stall. No-FWD build: same pair -> 2 stall cycles.
//  3 LW R5 then ex_redirect on the consumer's cycle -> flush_if_id=1, stall_if_id=0, cnt[R5] still decays.
//  4 Reader of R0 after any write to rd=0 -> never stalls; JAL then JR R15 (FWD) -> no stall.
//  5 HLT with LW R1 in MEM -> DRAIN for 3 cycles, halted=1 on 4th, remains 1; rst -> halted=0.
//  6 LW R1, LW R1 back-to-back (WAW) then reader of R1 -> stall count set by second LW only.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared opcodes, FSM states and producer latencies for the hazard scheduler.
// Build option: HAZARD_FWD_EN selects the forwarding latencies.
package hazard_ctrl_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;

  localparam logic [1:0] LOAD_LAT     = 2'd1;
  localparam logic [1:0] NOFWD_LAT    = 2'd2;
  localparam logic [1:0] DRAIN_CYCLES = 2'd3;

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_LHB = 4'b1010;
  localparam logic [3:0] OP_LLB = 4'b1011;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_JAL = 4'b1101;
  localparam logic [3:0] OP_JR  = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } sched_state_e;

  typedef enum logic {
    LAT_ALU  = 1'b0,
    LAT_LOAD = 1'b1
  } lat_class_e;

  function automatic lat_class_e lat_class_of(input logic [3:0] op);
    return (op == OP_LW) ? LAT_LOAD : LAT_ALU;
  endfunction

  // Bubbles a consumer must wait behind a producer of the given class.
  function automatic logic [1:0] lat_cycles(input lat_class_e cls);
`ifdef HAZARD_FWD_EN
    return (cls == LAT_LOAD) ? LOAD_LAT : 2'd0;
`else
    return (cls == LAT_LOAD) ? NOFWD_LAT : NOFWD_LAT;
`endif
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write counters with two busy lookups for the ID read ports.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc,
  input  logic [REG_AW-1:0] alloc_addr,
  input  logic [1:0]        alloc_lat,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic              rs_re,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic              rt_re,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              idle
);

  logic [1:0] cnt [NUM_REGS];

  // Allocation overwrites (WAW); every other counter keeps draining, bubbles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (alloc && (i != 0) && (alloc_addr == REG_AW'(i)))
          cnt[i] <= alloc_lat;
        else if (cnt[i] != 2'd0)
          cnt[i] <= cnt[i] - 2'd1;
      end
    end
  end

  always_comb begin
    idle = 1'b1;
    for (int i = 0; i < NUM_REGS; i++)
      if (cnt[i] != 2'd0) idle = 1'b0;
  end

  assign rs_busy = rs_re && (rs_addr != '0) && (cnt[rs_addr] != 2'd0);
  assign rt_busy = rt_re && (rt_addr != '0) && (cnt[rt_addr] != 2'd0);

endmodule

// File: rtl/hazard_sched_ctrl.sv
// Pipeline hazard scheduler: RAW stalls, redirect flushes and HLT drain sequencing.
// Build option: HAZARD_FWD_EN (EX/MEM forwarding latencies, see hazard_ctrl_pkg).
//
// state     | meaning
// ST_RUN    | normal issue; stall on RAW hazard, flush on redirect
// ST_DRAIN  | HLT issued; hold front end until EX/MEM/WB are empty
// ST_HALTED | core drained; front end held until reset
module hazard_sched_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_op,
  input  logic [3:0] id_rs_addr,
  input  logic       id_rs_re,
  input  logic [3:0] id_rt_addr,
  input  logic       id_rt_re,
  input  logic [3:0] id_rd_addr,
  input  logic       ex_redirect,
  output logic       stall_if_id,
  output logic       bubble_id_ex,
  output logic       flush_if_id,
  output logic       halted
);

  sched_state_e state;
  logic [1:0]   drain_cnt;
  logic         rs_busy, rt_busy, sb_idle;
  logic         hazard, alloc;

  assign hazard = id_valid && (rs_busy || rt_busy);

  hazard_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .alloc      (alloc),
    .alloc_addr (id_rd_addr),
    .alloc_lat  (lat_cycles(lat_class_of(id_op))),
    .rs_addr    (id_rs_addr),
    .rs_re      (id_rs_re),
    .rt_addr    (id_rt_addr),
    .rt_re      (id_rt_re),
    .rs_busy    (rs_busy),
    .rt_busy    (rt_busy),
    .idle       (sb_idle)
  );

  // Outputs decode state and ID inputs directly so a stall lands in the hazard cycle.
  // HALTED also bubbles ID/EX so the held IF/ID instruction never issues.
  always_comb begin
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    halted       = 1'b0;
    alloc        = 1'b0;
    case (state)
      ST_RUN: begin
        if (ex_redirect) begin
          flush_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
        end else if (hazard) begin
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
        end else begin
          alloc = id_valid && (id_rd_addr != 4'd0);
        end
      end
      ST_DRAIN: begin
        if (ex_redirect) begin
          flush_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
        end else begin
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
        end
      end
      ST_HALTED: begin
        halted       = 1'b1;
        stall_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= 2'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (id_valid && (id_op == OP_HLT) && !hazard && !ex_redirect) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_CYCLES;
          end
        end
        ST_DRAIN: begin
          if (ex_redirect) begin
            state     <= ST_RUN;
            drain_cnt <= 2'd0;
          end else begin
            if (drain_cnt != 2'd0) drain_cnt <= drain_cnt - 2'd1;
            // Last drain cycle: leave only once no write is still in flight.
            if ((drain_cnt <= 2'd1) && sb_idle) state <= ST_HALTED;
          end
        end
        ST_HALTED: ;
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Directed-vector bench for hazard_sched_ctrl; expectations follow the HAZARD_FWD_EN build option.
module tb_hazard_sched_ctrl;
  import hazard_ctrl_pkg::*;

`ifdef HAZARD_FWD_EN
  localparam int ALU_L = 0;
  localparam int LD_L  = 1;
`else
  localparam int ALU_L = 2;
  localparam int LD_L  = 2;
`endif

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;

  // Expected output nibble order: {stall_if_id, bubble_id_ex, flush_if_id, halted}
  localparam logic [3:0] O_RUN   = 4'b0000;
  localparam logic [3:0] O_STALL = 4'b1100;
  localparam logic [3:0] O_FLUSH = 4'b0110;
  localparam logic [3:0] O_HALT  = 4'b1101;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_op, id_rs_addr, id_rt_addr, id_rd_addr;
  logic       id_rs_re, id_rt_re, ex_redirect;
  logic       stall_if_id, bubble_id_ex, flush_if_id, halted;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_sched_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_op        (id_op),
    .id_rs_addr   (id_rs_addr),
    .id_rs_re     (id_rs_re),
    .id_rt_addr   (id_rt_addr),
    .id_rt_re     (id_rt_re),
    .id_rd_addr   (id_rd_addr),
    .ex_redirect  (ex_redirect),
    .stall_if_id  (stall_if_id),
    .bubble_id_ex (bubble_id_ex),
    .flush_if_id  (flush_if_id),
    .halted       (halted)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got sbfh=%b expected sbfh=%b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [3:0] rs, input logic rs_re,
                       input logic [3:0] rt, input logic rt_re,
                       input logic [3:0] rd, input logic redir);
    id_valid    = v;
    id_op       = op;
    id_rs_addr  = rs;
    id_rs_re    = rs_re;
    id_rt_addr  = rt;
    id_rt_re    = rt_re;
    id_rd_addr  = rd;
    ex_redirect = redir;
  endtask

  task automatic cycle_chk(input string tag, input logic [3:0] exp);
    @(negedge clk);
    chk(tag, {stall_if_id, bubble_id_ex, flush_if_id, halted}, exp);
    @(posedge clk);
    #1;
  endtask

  // Consumer held in ID: n stall cycles, then it issues.
  task automatic hold_then_issue(input string tag, input int n);
    for (int k = 0; k < n; k++) cycle_chk(tag, O_STALL);
    cycle_chk(tag, O_RUN);
  endtask

  task automatic idle_cycles();
    drive(1'b0, OP_ADD, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, OP_ADD, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    cycle_chk("reset", O_RUN);
    rst = 1'b0;

    // LW R1 ; ADD R2,R1,R3
    drive(1'b1, OP_LW, 4'd2, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0);
    cycle_chk("lw_issue", O_RUN);
    drive(1'b1, OP_ADD, 4'd1, 1'b1, 4'd3, 1'b1, 4'd2, 1'b0);
    hold_then_issue("lw_use", LD_L);
    idle_cycles();

    // ADD R1 ; SUB R4,R1,R1
    drive(1'b1, OP_ADD, 4'd5, 1'b1, 4'd6, 1'b1, 4'd1, 1'b0);
    cycle_chk("alu_issue", O_RUN);
    drive(1'b1, OP_SUB, 4'd1, 1'b1, 4'd1, 1'b1, 4'd4, 1'b0);
    hold_then_issue("alu_use", ALU_L);
    idle_cycles();

    // LW R5 ; redirect on consumer (ADD R6,R5,R0) ; reader of R5,R6
    drive(1'b1, OP_LW, 4'd2, 1'b1, 4'd0, 1'b0, 4'd5, 1'b0);
    cycle_chk("lw5_issue", O_RUN);
    drive(1'b1, OP_ADD, 4'd5, 1'b1, 4'd0, 1'b1, 4'd6, 1'b1);
    cycle_chk("redirect", O_FLUSH);
    drive(1'b1, OP_ADD, 4'd5, 1'b1, 4'd6, 1'b1, 4'd7, 1'b0);
    hold_then_issue("post_redir", LD_L - 1);
    idle_cycles();

    // write to R0 then reader of R0
    drive(1'b1, OP_ADD, 4'd2, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0);
    cycle_chk("r0_write", O_RUN);
    drive(1'b1, OP_ADD, 4'd0, 1'b1, 4'd0, 1'b1, 4'd8, 1'b0);
    cycle_chk("r0_read", O_RUN);
    idle_cycles();

    // JAL (R15) ; JR R15
    drive(1'b1, OP_JAL, 4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b0);
    cycle_chk("jal", O_RUN);
    drive(1'b1, OP_JR, 4'd15, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    hold_then_issue("jr_r15", ALU_L);
    idle_cycles();

    // WAW: LW R1 ; LW R1 ; reader of R1
    drive(1'b1, OP_LW, 4'd2, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0);
    cycle_chk("waw_lw1", O_RUN);
    drive(1'b1, OP_LW, 4'd3, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0);
    cycle_chk("waw_lw2", O_RUN);
    drive(1'b1, OP_ADD, 4'd1, 1'b1, 4'd0, 1'b0, 4'd9, 1'b0);
    hold_then_issue("waw_use", LD_L);
    idle_cycles();

    // Reset during a stall clears the scoreboard
    drive(1'b1, OP_LW, 4'd2, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0);
    cycle_chk("rst_lw", O_RUN);
    drive(1'b1, OP_ADD, 4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 1'b0);
    cycle_chk("rst_stall", O_STALL);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle_chk("rst_clear", O_RUN);
    idle_cycles();

    // HLT then redirect while draining -> back to RUN
    drive(1'b1, OP_HLT, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    cycle_chk("hlt_wrong", O_RUN);
    drive(1'b1, OP_ADD, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    cycle_chk("drain_redir", O_FLUSH);
    drive(1'b1, OP_ADD, 4'd2, 1'b1, 4'd0, 1'b0, 4'd3, 1'b0);
    cycle_chk("back_run", O_RUN);
    idle_cycles();

    // LW R1 ; filler ; HLT -> 3 drain cycles, then halted sticky
    drive(1'b1, OP_LW, 4'd2, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0);
    cycle_chk("h_lw", O_RUN);
    drive(1'b1, OP_ADD, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    cycle_chk("h_fill", O_RUN);
    drive(1'b1, OP_HLT, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    cycle_chk("h_hlt", O_RUN);
    drive(1'b1, OP_ADD, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 3; k++) cycle_chk("h_drain", O_STALL);
    cycle_chk("h_halted", O_HALT);
    cycle_chk("h_sticky", O_HALT);
    drive(1'b1, OP_ADD, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    cycle_chk("h_redir", O_HALT);
    drive(1'b0, OP_ADD, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle_chk("h_rst", O_RUN);
    rst = 1'b0;
    cycle_chk("h_after", O_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
